// File: rtl/inst_fetch_queue_pkg.sv
// Shared fetch-side types and constants for the
// instruction prefetch queue.
package inst_fetch_queue_pkg;

  localparam int FETCH_Q_DEPTH = 4;
  localparam logic [31:0] NOP_INS = 32'h0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        exc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo_mem.sv
// Entry storage for the fetch queue: one write port,
// one combinational read port, data is not reset.
module fetch_fifo_mem
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = FETCH_Q_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         we,
  input  logic [AW-1:0] waddr,
  input  fetch_entry_t wdata,
  input  logic [AW-1:0] raddr,
  output fetch_entry_t rdata
);

  fetch_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/inst_fetch_queue.sv
// Prefetch buffer between icache responses and decode,
// with credit flow control and redirect flushing.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = FETCH_Q_DEPTH,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          req_fire,
  output logic          req_allow,
  input  logic          resp_valid,
  input  logic [31:0]   resp_pc,
  input  logic [31:0]   resp_ins,
  input  logic          resp_exc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_ins,
  output logic          out_exc,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] pending_q, pending_d;
  logic [CW-1:0] discard_q, discard_d;
  fetch_entry_t  head_q, head_d;
  fetch_entry_t  wr_entry, rd_entry;
  logic          push, pop;

  assign req_allow = ({1'b0, count_q} + {1'b0, pending_q})
                     < (CW+1)'(DEPTH);
  assign out_valid = (count_q != '0);
  assign count     = count_q;
  assign out_pc    = head_q.pc;
  assign out_ins   = head_q.ins;
  assign out_exc   = head_q.exc;

  assign pop  = out_valid & out_ready & ~flush;
  assign push = resp_valid & (discard_q == '0) & ~flush;

  assign wr_entry.pc  = resp_pc;
  assign wr_entry.ins = resp_exc ? NOP_INS : resp_ins;
  assign wr_entry.exc = resp_exc;

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    discard_d = discard_q;
    head_d    = head_q;
    pending_d = pending_q + CW'(req_fire) - CW'(resp_valid);
    if (flush) begin
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
      discard_d = pending_q - CW'(resp_valid);
    end else begin
      if (resp_valid && discard_q != '0) begin
        discard_d = discard_q - CW'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
      // Next head may be the slot being written this cycle
      if (count_d != '0) begin
        head_d = (push && wr_ptr_q == rd_ptr_d) ? wr_entry
                                                : rd_entry;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
      discard_q <= '0;
      head_q    <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      discard_q <= discard_d;
      head_q    <= head_d;
    end
  end

  fetch_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_d),
    .rdata (rd_entry)
  );

  always @(posedge clk) begin
    if (resetn) begin
      assert (!(req_fire && !req_allow));
      assert (!(push && !pop && count_q == CW'(DEPTH)));
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed self-checking bench for inst_fetch_queue.
module tb_inst_fetch_queue;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        req_fire;
  logic        req_allow;
  logic        resp_valid;
  logic [31:0] resp_pc;
  logic [31:0] resp_ins;
  logic        resp_exc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_ins;
  logic        out_exc;
  logic [2:0]  count;

  int checks;
  int failures;

  inst_fetch_queue #(.DEPTH(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .req_fire   (req_fire),
    .req_allow  (req_allow),
    .resp_valid (resp_valid),
    .resp_pc    (resp_pc),
    .resp_ins   (resp_ins),
    .resp_exc   (resp_exc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_ins    (out_ins),
    .out_exc    (out_exc),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush      = 1'b0;
    req_fire   = 1'b0;
    resp_valid = 1'b0;
    resp_pc    = 32'h0;
    resp_ins   = 32'h0;
    resp_exc   = 1'b0;
    out_ready  = 1'b0;
  endtask

  function automatic logic [31:0] spc(input int k);
    return 32'h0000_1000 + 32'(4 * k);
  endfunction

  function automatic logic [31:0] sins(input int k);
    return 32'hA5A5_0000 ^ 32'(k);
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    idle();
    #3;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_ins", out_ins, 32'h0);
    chk("rst_exc", 32'(out_exc), 32'd0);
    chk("rst_allow", 32'(req_allow), 32'd1);
    #9;
    resetn = 1'b1;

    // fill and drain
    req_fire = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (i == 2) chk("fill_allow3", 32'(req_allow), 32'd1);
    end
    chk("fill_allow4", 32'(req_allow), 32'd0);
    req_fire = 1'b0;
    for (int i = 0; i < 4; i++) begin
      resp_valid = 1'b1;
      resp_pc    = 32'hBFC0_0000 + 32'(4 * i);
      resp_ins   = 32'h1000_0000 + 32'(i);
      cyc();
      if (i == 0) chk("fill_pc0", out_pc, 32'hBFC0_0000);
    end
    resp_valid = 1'b0;
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_allow_full", 32'(req_allow), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", out_pc, 32'hBFC0_0000 + 32'(4 * i));
      chk("drain_ins", out_ins, 32'h1000_0000 + 32'(i));
      cyc();
      if (i == 0) chk("drain_allow", 32'(req_allow), 32'd1);
    end
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // latency
    req_fire = 1'b1;
    cyc();
    req_fire   = 1'b0;
    resp_valid = 1'b1;
    resp_pc    = 32'hBFC0_0000;
    resp_ins   = 32'h2408_0001;
    #1;
    chk("lat_valid_N", 32'(out_valid), 32'd0);
    cyc();
    resp_valid = 1'b0;
    chk("lat_valid_N1", 32'(out_valid), 32'd1);
    chk("lat_pc", out_pc, 32'hBFC0_0000);
    chk("lat_ins", out_ins, 32'h2408_0001);
    chk("lat_exc", 32'(out_exc), 32'd0);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;

    // fetch exception
    req_fire = 1'b1;
    cyc();
    req_fire   = 1'b0;
    resp_valid = 1'b1;
    resp_pc    = 32'hBFC0_0002;
    resp_ins   = 32'h8C00_0000;
    resp_exc   = 1'b1;
    cyc();
    idle();
    chk("exc_flag", 32'(out_exc), 32'd1);
    chk("exc_ins", out_ins, 32'h0);
    chk("exc_pc", out_pc, 32'hBFC0_0002);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("exc_pop", 32'(count), 32'd0);

    // flush with two queued and two in flight
    req_fire = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    req_fire = 1'b0;
    for (int i = 0; i < 2; i++) begin
      resp_valid = 1'b1;
      resp_pc    = 32'h0000_2000 + 32'(4 * i);
      resp_ins   = 32'h0000_0011;
      cyc();
    end
    chk("pre_flush_count", 32'(count), 32'd2);
    flush      = 1'b1;
    resp_valid = 1'b1;
    resp_pc    = 32'hDEAD_0000;
    out_ready  = 1'b1;
    cyc();
    idle();
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_discard", 32'(dut.discard_q), 32'd1);
    chk("flush_allow", 32'(req_allow), 32'd1);
    req_fire   = 1'b1;
    resp_valid = 1'b1;
    resp_pc    = 32'hDEAD_0004;
    resp_ins   = 32'hFFFF_FFFF;
    cyc();
    chk("stale_drop", 32'(count), 32'd0);
    req_fire = 1'b0;
    resp_pc  = 32'h8000_0180;
    resp_ins = 32'h4200_0018;
    cyc();
    idle();
    chk("new_count", 32'(count), 32'd1);
    chk("new_pc", out_pc, 32'h8000_0180);
    chk("new_ins", out_ins, 32'h4200_0018);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;

    // steady push/pop at count 2 across pointer wrap
    req_fire = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    req_fire = 1'b0;
    for (int k = 0; k < 2; k++) begin
      resp_valid = 1'b1;
      resp_pc    = spc(k);
      resp_ins   = sins(k);
      cyc();
    end
    chk("pp_start", 32'(count), 32'd2);
    req_fire  = 1'b1;
    out_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      resp_pc  = spc(j + 2);
      resp_ins = sins(j + 2);
      chk("pp_pc", out_pc, spc(j));
      chk("pp_ins", out_ins, sins(j));
      cyc();
      chk("pp_count", 32'(count), 32'd2);
    end
    req_fire   = 1'b0;
    resp_valid = 1'b0;
    for (int j = 10; j < 12; j++) begin
      chk("pp_tail", out_pc, spc(j));
      cyc();
    end
    out_ready = 1'b0;
    chk("pp_empty", 32'(count), 32'd0);

    // async reset mid-burst, count=3 pending=1
    req_fire = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    req_fire = 1'b0;
    for (int i = 0; i < 3; i++) begin
      resp_valid = 1'b1;
      resp_pc    = 32'h0000_3000 + 32'(4 * i);
      resp_ins   = 32'h0000_0022;
      cyc();
    end
    chk("mid_count", 32'(count), 32'd3);
    chk("mid_pending", 32'(dut.pending_q), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_pc", out_pc, 32'h0);
    chk("arst_ins", out_ins, 32'h0);
    chk("arst_exc", 32'(out_exc), 32'd0);
    chk("arst_allow", 32'(req_allow), 32'd1);
    idle();
    #3;
    resetn = 1'b1;
    cyc();
    chk("post_allow", 32'(req_allow), 32'd1);
    chk("post_count", 32'(count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
